// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : router_pkg
//  Purpose  : Shared constants, flit layout and XY route helper for the
//             five-port mesh router.
//  Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  // Port indices; the same numbering is used for inputs and outputs.
  localparam int NPORTS = 5;
  localparam int P_L    = 0;
  localparam int P_N    = 1;
  localparam int P_E    = 2;
  localparam int P_S    = 3;
  localparam int P_W    = 4;

  // Flit field offsets (40-bit flit).
  localparam int SRC_LSB  = 36;
  localparam int SRC_W    = 4;
  localparam int DST_LSB  = 32;
  localparam int DST_W    = 4;
  localparam int TS_LSB   = 24;
  localparam int TS_W     = 8;
  localparam int DATA_LSB = 2;
  localparam int DATA_W   = 22;
  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 2;

  // Widest coordinate the route helper compares; narrower ones are zero-extended.
  localparam int ROUTE_CW = 8;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_SINGLE = 2'd3
  } flit_type_e;

  typedef logic [NPORTS-1:0] port_vec_t;

  // Dimension-ordered route: resolve x first, then y, else deliver locally.
  // dst is {dst_x, dst_y}; the result is a one-hot output port vector.
  function automatic port_vec_t xy_route(input logic [2*ROUTE_CW-1:0] dst,
                                         input logic [ROUTE_CW-1:0]   x,
                                         input logic [ROUTE_CW-1:0]   y);
    logic [ROUTE_CW-1:0] dx;
    logic [ROUTE_CW-1:0] dy;
    port_vec_t           dir;
    dx  = dst[2*ROUTE_CW-1:ROUTE_CW];
    dy  = dst[ROUTE_CW-1:0];
    dir = '0;
    if (dx > x)      dir[P_E] = 1'b1;
    else if (dx < x) dir[P_W] = 1'b1;
    else if (dy > y) dir[P_S] = 1'b1;
    else if (dy < y) dir[P_N] = 1'b1;
    else             dir[P_L] = 1'b1;
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : router_in_fifo
//  Purpose  : Per-input flit FIFO with registered full flag and occupancy.
//             Pointers wrap freely; occupancy lives in its own counter.
//  Revision : 1.0 - initial release
// ============================================================================
module router_in_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [DATASIZE-1:0] data_i,
  input  logic                pop_i,
  output logic [DATASIZE-1:0] head_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [WIDTH:0]      count_o
);

  localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0]    wr_ptr_q;
  logic [WIDTH-1:0]    rd_ptr_q;
  logic [WIDTH:0]      count_q;
  logic [WIDTH:0]      count_d;
  logic                full_q;
  logic                do_push;
  logic                do_pop;

  // The full flag is registered, so a pop while full frees the slot only
  // from the following cycle on.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & (count_q != '0);

  // Occupancy next state: push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and full-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_COUNT);
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mesh_router_xy.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_router_xy
//  Purpose  : Five-port XY mesh router: input FIFOs, combinational route on
//             each head, per-output round-robin allocation, registered
//             outputs. Ports cleared in PORT_EN are compiled out, and flits
//             routed towards them are dropped and counted.
//  Revision : 1.0 - initial release
// ============================================================================
module mesh_router_xy
  import router_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          WIDTH    = 3,
  parameter int          DATASIZE = 40,
  parameter int          COORD_W  = 2,
  parameter int          X_POS    = 0,
  parameter int          Y_POS    = 0,
  parameter logic [4:0]  PORT_EN  = 5'b11111
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS*DATASIZE-1:0]     in_data,
  input  logic [NPORTS-1:0]              in_valid,
  output logic [NPORTS-1:0]              in_full,
  output logic [NPORTS*(WIDTH+1)-1:0]    in_pressure,
  output logic [NPORTS*DATASIZE-1:0]     out_data,
  output logic [NPORTS-1:0]              out_valid,
  input  logic [NPORTS-1:0]              out_full,
  output logic [7:0]                     drop_cnt
);

  logic [NPORTS*DATASIZE-1:0] head_flat;
  logic [NPORTS-1:0]          empty;
  logic [NPORTS-1:0]          pop;
  logic [NPORTS-1:0]          drop;
  // req_flat[i*NPORTS + o]: input i's head wants output o.
  logic [NPORTS*NPORTS-1:0]   req_flat;
  // gnt_flat[o*NPORTS + i]: output o grants input i this cycle.
  logic [NPORTS*NPORTS-1:0]   gnt_flat;
  logic [7:0]                 drop_cnt_q;
  logic [7:0]                 drop_cnt_d;
  logic [8:0]                 drop_sum;

  // --------------------------------------------------------------------------
  // Input FIFOs, only for enabled ports.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    if (PORT_EN[p]) begin : g_en
      router_in_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .DATASIZE (DATASIZE)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid[p]),
        .data_i  (in_data[p*DATASIZE +: DATASIZE]),
        .pop_i   (pop[p]),
        .head_o  (head_flat[p*DATASIZE +: DATASIZE]),
        .empty_o (empty[p]),
        .full_o  (in_full[p]),
        .count_o (in_pressure[p*(WIDTH+1) +: (WIDTH+1)])
      );
    end else begin : g_dis
      // A missing port looks permanently full and empty to its neighbours.
      logic unused_in;
      assign unused_in = ^{in_data[p*DATASIZE +: DATASIZE], in_valid[p], pop[p]};
      assign head_flat[p*DATASIZE +: DATASIZE]       = '0;
      assign empty[p]                                = 1'b1;
      assign in_full[p]                              = 1'b1;
      assign in_pressure[p*(WIDTH+1) +: (WIDTH+1)]   = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Route computation on each FIFO head.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NPORTS; p++) begin : g_route
    logic [2*COORD_W-1:0] dst;
    port_vec_t            dir;
    assign dst = head_flat[p*DATASIZE + DST_LSB +: 2*COORD_W];
    assign dir = xy_route({ROUTE_CW'(dst[2*COORD_W-1:COORD_W]), ROUTE_CW'(dst[COORD_W-1:0])},
                          ROUTE_CW'(X_POS), ROUTE_CW'(Y_POS));
    assign req_flat[p*NPORTS +: NPORTS] = empty[p] ? '0 : (dir & PORT_EN);
    assign drop[p] = ~empty[p] & (|(dir & ~PORT_EN));
  end

  // --------------------------------------------------------------------------
  // Per-output round-robin arbiter and output register.
  // --------------------------------------------------------------------------
  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    if (PORT_EN[o]) begin : g_en
      logic [2:0]          ptr_q;
      logic [2:0]          ptr_d;
      logic [NPORTS-1:0]   reqs;
      logic [NPORTS-1:0]   gnt;
      logic [DATASIZE-1:0] sel_data;
      logic [DATASIZE-1:0] data_q;
      logic                valid_q;

      // Collect the heads that target this output.
      always_comb begin
        reqs = '0;
        for (int i = 0; i < NPORTS; i++) reqs[i] = req_flat[i*NPORTS + o];
      end

      // Search from the pointer for the first requester; a blocked output grants nothing.
      always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        ptr_d = ptr_q;
        if (!out_full[o]) begin
          for (int k = 0; k < NPORTS; k++) begin
            idx = (int'(ptr_q) + k) % NPORTS;
            if ((gnt == '0) && reqs[idx]) begin
              gnt[idx] = 1'b1;
              ptr_d    = 3'((idx + 1) % NPORTS);
            end
          end
        end
      end

      // One-hot mux of the granted head.
      always_comb begin
        sel_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
          if (gnt[i]) sel_data = sel_data | head_flat[i*DATASIZE +: DATASIZE];
        end
      end

      // Output register: valid pulses per grant, data holds between grants.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ptr_q   <= '0;
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          ptr_q   <= ptr_d;
          valid_q <= |gnt;
          if (|gnt) data_q <= sel_data;
        end
      end

      assign gnt_flat[o*NPORTS +: NPORTS]      = gnt;
      assign out_data[o*DATASIZE +: DATASIZE]  = data_q;
      assign out_valid[o]                      = valid_q;
    end else begin : g_dis
      logic unused_full;
      assign unused_full                       = out_full[o];
      assign gnt_flat[o*NPORTS +: NPORTS]      = '0;
      assign out_data[o*DATASIZE +: DATASIZE]  = '0;
      assign out_valid[o]                      = 1'b0;
    end
  end

  // An input pops when its head is granted or dropped.
  always_comb begin
    pop = drop;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (gnt_flat[o*NPORTS + i]) pop[i] = 1'b1;
      end
    end
  end

  // Saturating drop total; several inputs may drop in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NPORTS; i++) drop_sum = drop_sum + {8'd0, drop[i]};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire
